// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared slot/key types and constants for the packet slot path
//
// Purpose: common sizes, typedefs and the "no slot" id shared by the slot
// allocator and the slot-match stage.
// Ports: none (package).
package pkt_pkg;

  localparam int SLOT_SIZE = 8;
  localparam int NUM_SLOTS = SLOT_SIZE * SLOT_SIZE;
  localparam int SLOT_ID_W = $clog2(NUM_SLOTS + 1);
  localparam int KEY_W     = 32;

  typedef logic [SLOT_ID_W-1:0] slot_id_t;
  typedef logic [KEY_W-1:0]     pkt_key_t;

  // Id 0 is reserved to mean "no slot"; real ids run 1..NUM_SLOTS.
  localparam int SLOT_NONE = 0;

endpackage

// File: rtl/pkt_slot_find.sv
// rtl/pkt_slot_find.sv - lowest-free-slot priority encoder over an occupancy bitmap
//
// Purpose: returns id k+1 of the lowest clear bit k in occ, or SLOT_NONE when
// every bit is set. Purely combinational.
// Ports:
//   occ     in  N  occupancy bitmap, bit k <-> slot id k+1
//   free_id out W  lowest free slot id, 0 when none
module pkt_slot_find
  import pkt_pkg::*;
#(
  parameter int N = NUM_SLOTS,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] occ,
  output logic [W-1:0] free_id
);

  // Scan from the top down so the last write wins with the lowest index.
  always_comb begin
    free_id = W'(SLOT_NONE);
    for (int k = N - 1; k >= 0; k--) begin
      if (!occ[k]) begin
        free_id = W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/pkt_slot_alloc.sv
// rtl/pkt_slot_alloc.sv - lowest-free slot allocator with registered result and free checking
//
// Purpose: keeps the SLOT_SIZE x SLOT_SIZE occupancy bitmap, hands each
// accepted packet the lowest free slot id through a one-entry output register,
// and reclaims slots on free requests.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready/in_key     packet request handshake and key
//   out_valid/out_ready          result handshake
//   out_key/out_slot             key and allocated slot id (1..NUM_SLOTS)
//   free_valid/free_slot         slot release request
//   occ_count/full/empty         occupancy status from registered state
//   free_err                     one-cycle pulse after an invalid or double free
module pkt_slot_alloc
  import pkt_pkg::*;
#(
  parameter int SLOT_SIZE = pkt_pkg::SLOT_SIZE,
  parameter int KEY_W     = pkt_pkg::KEY_W,
  parameter int ID_W      = $clog2(SLOT_SIZE * SLOT_SIZE + 1),
  parameter int CNT_W     = $clog2(SLOT_SIZE * SLOT_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_key,
  output logic [ID_W-1:0]  out_slot,
  input  logic             free_valid,
  input  logic [ID_W-1:0]  free_slot,
  output logic [CNT_W-1:0] occ_count,
  output logic             full,
  output logic             empty,
  output logic             free_err
);

  localparam int NSLOTS = SLOT_SIZE * SLOT_SIZE;

  logic [NSLOTS-1:0] occ_q, occ_d;
  logic [CNT_W-1:0]  occ_count_q, occ_count_d;
  logic              out_valid_q, out_valid_d;
  logic [KEY_W-1:0]  out_key_q, out_key_d;
  logic [ID_W-1:0]   out_slot_q, out_slot_d;
  logic              free_err_q, free_err_d;

  logic [ID_W-1:0]   cand_id;
  logic              out_space;
  logic              accept;
  logic              free_hit;
  logic              valid_free;

  // Search runs on the pre-update bitmap, so a slot freed this cycle only
  // becomes allocatable on the next one.
  pkt_slot_find #(
    .N (NSLOTS),
    .W (ID_W)
  ) u_find (
    .occ     (occ_q),
    .free_id (cand_id)
  );

  always_comb begin
    out_space = !out_valid_q || out_ready;
    in_ready  = (cand_id != ID_W'(SLOT_NONE)) && out_space;
    accept    = in_valid && in_ready;

    // A free is good only if it names an occupied slot in 1..NSLOTS; id 0 and
    // out-of-range ids never match any k, so they fall out as errors.
    free_hit = 1'b0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (free_slot == ID_W'(k + 1)) begin
        free_hit = occ_q[k];
      end
    end
    valid_free = free_valid && free_hit;
    free_err_d = free_valid && !free_hit;

    // Allocation and release never target the same bit: the candidate is
    // clear while a valid free requires a set bit.
    occ_d = occ_q;
    for (int k = 0; k < NSLOTS; k++) begin
      if (accept && (cand_id == ID_W'(k + 1))) begin
        occ_d[k] = 1'b1;
      end
      if (valid_free && (free_slot == ID_W'(k + 1))) begin
        occ_d[k] = 1'b0;
      end
    end

    occ_count_d = occ_count_q + CNT_W'(accept) - CNT_W'(valid_free);

    out_valid_d = out_valid_q;
    out_key_d   = out_key_q;
    out_slot_d  = out_slot_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_key_d   = in_key;
      out_slot_d  = cand_id;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= '0;
      occ_count_q <= '0;
      out_valid_q <= 1'b0;
      out_key_q   <= '0;
      out_slot_q  <= '0;
      free_err_q  <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      occ_count_q <= occ_count_d;
      out_valid_q <= out_valid_d;
      out_key_q   <= out_key_d;
      out_slot_q  <= out_slot_d;
      free_err_q  <= free_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_key   = out_key_q;
  assign out_slot  = out_slot_q;
  assign occ_count = occ_count_q;
  assign free_err  = free_err_q;
  assign full      = (occ_count_q == CNT_W'(NSLOTS));
  assign empty     = (occ_count_q == '0);

endmodule

// File: tb/tb_pkt_slot_alloc.sv
// tb/tb_pkt_slot_alloc.sv - directed self-checking bench for pkt_slot_alloc
module tb_pkt_slot_alloc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_key = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_key;
  logic [6:0]  out_slot;
  logic        free_valid = 1'b0;
  logic [6:0]  free_slot = '0;
  logic [6:0]  occ_count;
  logic        full;
  logic        empty;
  logic        free_err;

  int errors = 0;
  int checks = 0;

  pkt_slot_alloc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key     (in_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_key    (out_key),
    .out_slot   (out_slot),
    .free_valid (free_valid),
    .free_slot  (free_slot),
    .occ_count  (occ_count),
    .full       (full),
    .empty      (empty),
    .free_err   (free_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    free_valid = 1'b0;
    out_ready  = 1'b1;
    rst_n      = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // Allocate n slots back to back, then drain the output register.
  task automatic alloc_n(input int n);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_key = 32'h1000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_slot !== 7'd0) begin errors++; $display("FAIL reset_out_slot got=%0d exp=0", out_slot); end
    checks++; if (out_key !== 32'd0) begin errors++; $display("FAIL reset_out_key got=%h exp=0", out_key); end
    checks++; if (occ_count !== 7'd0) begin errors++; $display("FAIL reset_occ_count got=%0d exp=0", occ_count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%0b full=%0b exp empty=1 full=0", empty, full); end
    checks++; if (free_err !== 1'b0) begin errors++; $display("FAIL reset_free_err got=%0b exp=0", free_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      in_key = 32'hB000_0000 + 32'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_slot !== 7'(i) || out_key !== 32'hB000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_alloc_%0d got valid=%0b slot=%0d key=%h exp valid=1 slot=%0d key=%h",
                 i, out_valid, out_slot, out_key, i, 32'hB000_0000 + 32'(i));
      end
    end
    checks++; if (full !== 1'b1 || occ_count !== 7'd64) begin errors++; $display("FAIL b2b_full got full=%0b count=%0d exp full=1 count=64", full, occ_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_at_full got=%0b exp=0", in_ready); end
  endtask

  task automatic test_full_free();
    // in_valid still high from the fill
    free_valid = 1'b1;
    free_slot  = 7'd5;
    in_key     = 32'hF5F5_0005;
    step();
    free_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_free_in_ready got=%0b exp=1", in_ready); end
    checks++; if (occ_count !== 7'd63 || full !== 1'b0) begin errors++; $display("FAIL full_free_count got=%0d full=%0b exp=63 full=0", occ_count, full); end
    step();
    checks++; if (out_slot !== 7'd5 || out_key !== 32'hF5F5_0005) begin errors++; $display("FAIL full_free_realloc got slot=%0d key=%h exp slot=5 key=f5f50005", out_slot, out_key); end
    checks++; if (occ_count !== 7'd64 || full !== 1'b1) begin errors++; $display("FAIL full_free_recount got=%0d full=%0b exp=64 full=1", occ_count, full); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_free_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1'b1;
    in_key = 32'h11; step();
    in_key = 32'h22; step();
    in_key = 32'hA5A5_0001; step();
    out_ready = 1'b0;
    in_key = 32'h44;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_slot !== 7'd3 || out_key !== 32'hA5A5_0001 || in_ready !== 1'b0 || occ_count !== 7'd3) begin
        errors++;
        $display("FAIL stall_cycle_%0d got valid=%0b slot=%0d key=%h rdy=%0b cnt=%0d exp 1/3/a5a50001/0/3",
                 c, out_valid, out_slot, out_key, in_ready, occ_count);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%0b exp=1", in_ready); end
    step();
    checks++; if (out_slot !== 7'd4 || out_key !== 32'h44 || occ_count !== 7'd4) begin errors++; $display("FAIL stall_next_accept got slot=%0d key=%h cnt=%0d exp 4/44/4", out_slot, out_key, occ_count); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_free_err();
    do_reset();
    alloc_n(8);
    checks++; if (occ_count !== 7'd8) begin errors++; $display("FAIL ferr_setup_count got=%0d exp=8", occ_count); end
    free_valid = 1'b1;
    free_slot  = 7'd7;
    step();
    checks++; if (occ_count !== 7'd7 || free_err !== 1'b0) begin errors++; $display("FAIL ferr_first_free got cnt=%0d err=%0b exp 7/0", occ_count, free_err); end
    step();
    checks++; if (occ_count !== 7'd7 || free_err !== 1'b1) begin errors++; $display("FAIL ferr_double_free got cnt=%0d err=%0b exp 7/1", occ_count, free_err); end
    free_slot = 7'd0;
    step();
    checks++; if (occ_count !== 7'd7 || free_err !== 1'b1) begin errors++; $display("FAIL ferr_id0 got cnt=%0d err=%0b exp 7/1", occ_count, free_err); end
    free_slot = 7'd65;
    step();
    checks++; if (occ_count !== 7'd7 || free_err !== 1'b1) begin errors++; $display("FAIL ferr_id65 got cnt=%0d err=%0b exp 7/1", occ_count, free_err); end
    free_valid = 1'b0;
    step();
    checks++; if (free_err !== 1'b0) begin errors++; $display("FAIL ferr_pulse_end got=%0b exp=0", free_err); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    alloc_n(4);
    in_valid   = 1'b1;
    in_key     = 32'h5555;
    free_valid = 1'b1;
    free_slot  = 7'd2;
    step();
    free_valid = 1'b0;
    in_key     = 32'h2222;
    checks++; if (out_slot !== 7'd5 || occ_count !== 7'd4) begin errors++; $display("FAIL same_cycle_alloc got slot=%0d cnt=%0d exp 5/4", out_slot, occ_count); end
    step();
    checks++; if (out_slot !== 7'd2 || out_key !== 32'h2222 || occ_count !== 7'd5) begin errors++; $display("FAIL same_cycle_reuse got slot=%0d key=%h cnt=%0d exp 2/2222/5", out_slot, out_key, occ_count); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_key = 32'(i);
      step();
    end
    checks++; if (out_slot !== 7'd10 || occ_count !== 7'd10) begin errors++; $display("FAIL mid_pre_reset got slot=%0d cnt=%0d exp 10/10", out_slot, occ_count); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occ_count !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_reset_async got valid=%0b cnt=%0d empty=%0b exp 0/0/1", out_valid, occ_count, empty); end
    step();
    rst_n  = 1'b1;
    in_key = 32'hCAFE;
    step();
    checks++; if (out_valid !== 1'b1 || out_slot !== 7'd1 || out_key !== 32'hCAFE) begin errors++; $display("FAIL mid_post_reset got valid=%0b slot=%0d key=%h exp 1/1/cafe", out_valid, out_slot, out_key); end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_free();
    test_stall();
    test_free_err();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
